// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } led_mode_t;

  // Channel-select width: a single channel still needs a one-bit select port.
  function automatic int ch_width(input int num_leds);
    return (num_leds <= 1) ? 1 : $clog2(num_leds);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode, effective period and tick counter and
// produces the registered LED level plus a one-cycle ONESHOT completion pulse.
module led_channel
  import led_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                wr,
  input  led_mode_t           mode,
  input  logic [PERIOD_W-1:0] period,
  output logic                led,
  output logic                done
);

  led_mode_t           mode_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] tcnt;
  logic                counting;
  logic                period_end;

  assign counting   = (mode_q == LED_BLINK) || (mode_q == LED_ONESHOT);
  assign period_end = (tcnt == per_q - PERIOD_W'(1));

  // A write takes priority over a coincident tick, so a freshly written
  // channel always starts counting from the next tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= LED_OFF;
      per_q  <= '0;
      tcnt   <= '0;
      led    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr) begin
        mode_q <= mode;
        per_q  <= (period == '0) ? PERIOD_W'(1) : period;
        tcnt   <= '0;
        led    <= (mode != LED_OFF);
      end else if (tick && counting) begin
        if (period_end) begin
          tcnt <= '0;
          if (mode_q == LED_BLINK) begin
            led <= ~led;
          end else begin
            led    <= 1'b0;
            mode_q <= LED_OFF;
            done   <= 1'b1;
          end
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write
// decode and one led_channel instance per LED.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter  int CLK_FREQ = 25_000_000,
  parameter  int TICK_HZ  = 1000,
  parameter  int NUM_LEDS = 8,
  parameter  int PERIOD_W = 16,
  localparam int CH_W     = ch_width(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_LEDS-1:0] leds,
  output logic [NUM_LEDS-1:0] oneshot_done,
  output logic                tick
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PCNT_W   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("led_pattern_gen: CLK_FREQ/TICK_HZ must be at least 2");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_bad_leds
    $error("led_pattern_gen: NUM_LEDS must be in 1..32");
  end

  logic [PCNT_W-1:0]   pcnt;
  logic [NUM_LEDS-1:0] wr_sel;

  // Free-running prescaler; tick is the registered wrap indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PCNT_W'(TICK_DIV - 1));
      if (pcnt == PCNT_W'(TICK_DIV - 1)) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Out-of-range channel numbers match no select line and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .wr     (wr_sel[g]),
      .mode   (led_mode_t'(cfg_mode)),
      .period (cfg_period),
      .led    (leds[g]),
      .done   (oneshot_done[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (TICK_DIV=10, 4 channels),
// with a 3-channel instance sharing the config bus to exercise invalid selects.
module tb_led_pattern_gen;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_period = '0;
  logic [3:0] leds;
  logic [3:0] oneshot_done;
  logic       tick;
  logic [2:0] leds3;
  logic [2:0] done3;
  logic       tick3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  led_pattern_gen #(
    .CLK_FREQ(100), .TICK_HZ(10), .NUM_LEDS(4), .PERIOD_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .leds(leds),
    .oneshot_done(oneshot_done), .tick(tick)
  );

  led_pattern_gen #(
    .CLK_FREQ(100), .TICK_HZ(10), .NUM_LEDS(3), .PERIOD_W(8)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .leds(leds3),
    .oneshot_done(done3), .tick(tick3)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] ch, input led_mode_t m, input logic [7:0] p);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = m;
    cfg_period = p;
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  // Consume n tick pulses, ending on the negedge after the last one is processed.
  task automatic wait_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n) begin
      if (tick) seen++;
      @(negedge clk);
      guard++;
      if (guard > 200 * n) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL wait_ticks timeout: saw %0d ticks, required %0d", seen, n);
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_tick;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      exp_tick = (cyc != 0) && (cyc % 10 == 0);
      n_checks++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("[TB] FAIL reset_tick cyc=%0d: got %b, required %b", cyc, tick, exp_tick);
      end
      n_checks++;
      if (tick3 !== exp_tick) begin
        n_fail++;
        $display("[TB] FAIL reset_tick3 cyc=%0d: got %b, required %b", cyc, tick3, exp_tick);
      end
      n_checks++;
      if (leds !== 4'b0000 || oneshot_done !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cyc=%0d: leds=%b done=%b, required 0000/0000",
                 cyc, leds, oneshot_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blink();
    logic exp_led;
    int   last;
    @(negedge clk);
    do_write(2'd0, LED_BLINK, 8'd3);
    n_checks++;
    if (leds[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL blink_start: got %b, required 1", leds[0]);
    end
    exp_led = 1'b1;
    last    = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ticks(2);
      n_checks++;
      if (leds[0] !== exp_led) begin
        n_fail++;
        $display("[TB] FAIL blink_hold%0d: got %b, required %b", k, leds[0], exp_led);
      end
      wait_ticks(1);
      exp_led = ~exp_led;
      n_checks++;
      if (leds[0] !== exp_led) begin
        n_fail++;
        $display("[TB] FAIL blink_toggle%0d: got %b, required %b", k, leds[0], exp_led);
      end
      if (k > 0) begin
        n_checks++;
        if (cyc - last !== 30) begin
          n_fail++;
          $display("[TB] FAIL blink_spacing%0d: got %0d cycles, required 30", k, cyc - last);
        end
      end
      last = cyc;
    end
  endtask

  task automatic test_oneshot();
    do_write(2'd1, LED_ONESHOT, 8'd2);
    n_checks++;
    if (leds[1] !== 1'b1 || oneshot_done[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oneshot_start: led=%b done=%b, required 1/0", leds[1], oneshot_done[1]);
    end
    wait_ticks(1);
    n_checks++;
    if (leds[1] !== 1'b1 || oneshot_done[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oneshot_mid: led=%b done=%b, required 1/0", leds[1], oneshot_done[1]);
    end
    wait_ticks(1);
    n_checks++;
    if (leds[1] !== 1'b0 || oneshot_done[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oneshot_end: led=%b done=%b, required 0/1", leds[1], oneshot_done[1]);
    end
    @(negedge clk);
    n_checks++;
    if (oneshot_done !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL oneshot_pulse_width: got %b, required 0000", oneshot_done);
    end
    wait_ticks(2);
    n_checks++;
    if (leds[1] !== 1'b0 || oneshot_done !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL oneshot_after: led=%b done=%b, required 0/0000", leds[1], oneshot_done);
    end
  endtask

  task automatic test_zero_period_and_invalid();
    do_write(2'd0, LED_OFF, 8'd0);
    do_write(2'd3, LED_ON, 8'd0);
    n_checks++;
    if (leds !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL on_write: got %b, required 1000", leds);
    end
    n_checks++;
    if (leds3 !== 3'b000 || done3 !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL invalid_ch: leds3=%b done3=%b, required 000/000", leds3, done3);
    end
    do_write(2'd2, LED_BLINK, 8'd0);
    n_checks++;
    if (leds !== 4'b1100 || leds3 !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL p0_start: leds=%b leds3=%b, required 1100/100", leds, leds3);
    end
    wait_ticks(1);
    n_checks++;
    if (leds !== 4'b1000 || leds3 !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL p0_tick1: leds=%b leds3=%b, required 1000/000", leds, leds3);
    end
    wait_ticks(1);
    n_checks++;
    if (leds !== 4'b1100 || leds3 !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL p0_tick2: leds=%b leds3=%b, required 1100/100", leds, leds3);
    end
  endtask

  task automatic test_write_tick_collision();
    int guard = 0;
    while (!tick && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL collide_align: tick=%b, required 1", tick);
    end
    do_write(2'd0, LED_BLINK, 8'd2);
    n_checks++;
    if (leds[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL collide_start: got %b, required 1", leds[0]);
    end
    wait_ticks(1);
    n_checks++;
    if (leds[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL collide_first_tick: got %b, required 1", leds[0]);
    end
    wait_ticks(1);
    n_checks++;
    if (leds[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL collide_toggle: got %b, required 0", leds[0]);
    end
  endtask

  task automatic test_reset_mid_oneshot();
    logic exp_tick;
    do_write(2'd1, LED_ONESHOT, 8'd5);
    wait_ticks(1);
    n_checks++;
    if (leds[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_pre: got %b, required 1", leds[1]);
    end
    do_reset();
    n_checks++;
    if (leds !== 4'b0000 || oneshot_done !== 4'b0000 || tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_clear: leds=%b done=%b tick=%b, required 0000/0000/0",
               leds, oneshot_done, tick);
    end
    for (int i = 0; i < 15; i++) begin
      exp_tick = (cyc != 0) && (cyc % 10 == 0);
      n_checks++;
      if (tick !== exp_tick || oneshot_done !== 4'b0000 || leds !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL midreset_after cyc=%0d: tick=%b done=%b leds=%b, required %b/0000/0000",
                 cyc, tick, oneshot_done, leds, exp_tick);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_oneshot();
    test_zero_period_and_invalid();
    test_write_tick_collision();
    test_reset_mid_oneshot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
